// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling at a fixed baud divisor,
// one-cycle rx_rdy strobe per good byte and frame_err strobe per bad stop bit.
module uart_rx #(
    parameter logic [11:0] BAUD = 12'd2605
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frame_err
);

    localparam logic [11:0] HALF = BAUD >> 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      r_state, w_state;
    logic        r_sync1, r_rx_s;
    logic [11:0] r_cnt, w_cnt;
    logic [3:0]  r_bitcnt, w_bitcnt;
    logic [7:0]  r_shift, w_shift;
    logic [7:0]  r_data, w_data;
    logic        r_rdy, w_rdy;
    logic        r_ferr, w_ferr;
    logic        w_tc;

    assign w_tc      = (r_cnt == 12'd1);
    assign rx_data   = r_data;
    assign rx_rdy    = r_rdy;
    assign frame_err = r_ferr;

    // Synchronizer presets high so reset can never look like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_state  <= S_IDLE;
            r_cnt    <= 12'd0;
            r_bitcnt <= 4'd0;
            r_data   <= 8'h00;
            r_rdy    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync1  <= RX;
            r_rx_s   <= r_sync1;
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bitcnt <= w_bitcnt;
            r_data   <= w_data;
            r_rdy    <= w_rdy;
            r_ferr   <= w_ferr;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift;
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_bitcnt = r_bitcnt;
        w_shift  = r_shift;
        w_data   = r_data;
        w_rdy    = 1'b0;
        w_ferr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_cnt   = HALF;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (w_tc) begin
                    if (r_rx_s) begin
                        w_state = S_IDLE;
                    end else begin
                        w_cnt    = BAUD;
                        w_bitcnt = 4'd0;
                        w_state  = S_DATA;
                    end
                end else begin
                    w_cnt = r_cnt - 12'd1;
                end
            end
            S_DATA: begin
                if (w_tc) begin
                    w_shift = {r_rx_s, r_shift[7:1]};
                    w_cnt   = BAUD;
                    if (r_bitcnt < 4'd8) begin
                        w_bitcnt = r_bitcnt + 4'd1;
                    end
                    if (r_bitcnt == 4'd7) begin
                        w_state = S_STOP;
                    end
                end else begin
                    w_cnt = r_cnt - 12'd1;
                end
            end
            S_STOP: begin
                if (w_tc) begin
                    w_cnt = BAUD;
                    if (r_rx_s) begin
                        w_data  = r_shift;
                        w_rdy   = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt = r_cnt - 12'd1;
                end
            end
            S_WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames at a reduced baud divisor and checks every strobe
// against a queue of expected bytes and nominal arrival times.
module tb_uart_rx;

    localparam int B   = 21;
    localparam int LAT = 9 * B + B / 2 + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frame_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] exp_b [512];
    int         exp_t [512];
    int         wr = 0;
    int         rd = 0;
    int         exp_ferr = 0;
    int         act_rdy = 0;
    int         act_ferr = 0;
    logic [7:0] model_last = 8'h00;
    logic       prev_rdy = 1'b0;

    uart_rx #(.BAUD(12'(B))) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check();
        int d;
        chk("strobe_overlap", {31'b0, rx_rdy & frame_err}, 32'd0);
        if (rx_rdy === 1'b1) begin
            act_rdy++;
            chk("rdy_width", {31'b0, prev_rdy}, 32'd0);
            chk("rdy_expected", {31'b0, wr > rd}, 32'd1);
            if (wr > rd) begin
                chk("rx_data", {24'b0, rx_data}, {24'b0, exp_b[rd]});
                d = cyc - exp_t[rd];
                vectors++;
                assert (d >= LAT - 2 && d <= LAT + 2) else begin
                    miscompares++;
                    $error("FAIL latency observed=%0d expected=%0d+-2", d, LAT);
                end
                model_last = exp_b[rd];
                rd++;
            end
        end else begin
            chk("rx_data_hold", {24'b0, rx_data}, {24'b0, model_last});
        end
        if (frame_err === 1'b1) act_ferr++;
        prev_rdy = rx_rdy;
    endtask

    // One clock: sample outputs on the falling edge, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        if (stop && rst_bit < 0) begin
            exp_b[wr] = b;
            exp_t[wr] = cyc;
            wr++;
        end else if (!stop) begin
            exp_ferr++;
        end
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            if (i == rst_bit) begin
                repeat (B / 2) tick();
                rst = 1'b1;
                model_last = 8'h00;
                prev_rdy = 1'b0;
                #2;
                rst = 1'b0;
                chk("midreset_data", {24'b0, rx_data}, 32'h00);
                chk("midreset_rdy", {31'b0, rx_rdy}, 32'd0);
                chk("midreset_ferr", {31'b0, frame_err}, 32'd0);
                repeat (B - B / 2) tick();
            end else begin
                repeat (B) tick();
            end
        end
    endtask

    initial begin
        logic [7:0] pat [5];
        logic [7:0] rb;
        int gap;
        pat[0] = 8'hFF; pat[1] = 8'h00; pat[2] = 8'h99; pat[3] = 8'hC3; pat[4] = 8'h93;

        #1;
        repeat (3) tick();
        chk("reset_data", {24'b0, rx_data}, 32'h00);
        chk("reset_rdy", {31'b0, rx_rdy}, 32'd0);
        chk("reset_ferr", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;
        idle(10000);
        chk("idle_rdy_count", act_rdy, 32'd0);
        chk("idle_ferr_count", act_ferr, 32'd0);

        send_frame(8'hA5, 1'b1, -1);
        idle(B);
        chk("single_rdy_count", act_rdy, wr);

        for (int f = 0; f < 98; f++) send_frame(pat[f % 5], 1'b1, -1);
        idle(B);
        chk("burst_rdy_count", act_rdy, wr);
        chk("burst_ferr_count", act_ferr, 32'd0);

        RX = 1'b0;
        repeat (B / 2 - 3) tick();
        idle(3 * B);
        chk("glitch_rdy_count", act_rdy, wr);
        chk("glitch_ferr_count", act_ferr, 32'd0);
        send_frame(8'h3C, 1'b1, -1);
        idle(B);
        chk("after_glitch_count", act_rdy, wr);

        send_frame(8'h5A, 1'b0, -1);
        repeat (5 * B) tick();
        idle(2 * B);
        chk("break_ferr_count", act_ferr, exp_ferr);
        chk("break_rdy_count", act_rdy, wr);
        send_frame(8'h81, 1'b1, -1);
        idle(B);
        chk("after_break_count", act_rdy, wr);

        send_frame(8'hF0, 1'b1, 5);
        idle(2 * B);
        chk("aborted_rdy_count", act_rdy, wr);
        send_frame(8'h0F, 1'b1, -1);
        idle(B);
        chk("after_reset_count", act_rdy, wr);

        for (int k = 0; k < 12; k++) begin
            rb  = 8'($urandom);
            gap = $urandom_range(0, 2 * B);
            send_frame(rb, 1'b1, -1);
            idle(gap);
        end

        idle(2 * B);
        chk("pending_frames", wr - rd, 32'd0);
        chk("final_rdy_count", act_rdy, wr);
        chk("final_ferr_count", act_ferr, exp_ferr);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
